i2s_tx_master: RTL and testbench
================================

Name: i2s_tx_master

Overview:
- I2S master transmitter feeding an external DAC; the playback counterpart of the microphone-capture path.
- Generates BCLK and WS from the system clock and serialises left/right PCM samples MSB-first in standard Philips I2S framing.
- Accepts samples through a valid/ready handshake into a one-deep holding buffer.
- Runs entirely in the clk domain; BCLK is a registered output, never used as a clock internally.

Parameters:
- CLK_DIV, 64, clk cycles per BCLK period; even, >=4
- WORD_SIZE, 32, BCLK periods per channel slot
- DATA_BITS, 24, sample width; DATA_BITS <= WORD_SIZE; slot bits beyond DATA_BITS are zero

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run request
- left_data  in  DATA_BITS  left sample
- right_data  in  DATA_BITS  right sample
- sample_valid  in  1  left_data/right_data pair valid
- sample_ready  out  1  holding buffer empty
- bclk  out  1  bit clock
- ws  out  1  word select; 0 = left slot, 1 = right slot
- sdata  out  1  serial data to DAC
- frame_start  out  1  one-clk pulse on each frame load
- underflow  out  1  one-clk pulse when a frame loads with the holding buffer empty

Behaviour:
- Reset (async, immediate, also mid-frame): bclk=0, ws=0, sdata=0, sample_ready=1, frame_start=0, underflow=0, holding buffer empty, state IDLE, all counters 0.
- States: IDLE and RUN.
  - IDLE: bclk, ws and sdata are held at 0; the divider is cleared.
  - IDLE->RUN when enable=1.
  - RUN->IDLE only at the end of a frame (last fall of pos 2*WORD_SIZE-1 has completed, next would be pos 0) with enable=0. An in-progress frame always completes.
- Divider: div_cnt counts 0..CLK_DIV/2-1. bclk toggles in the cycle div_cnt==CLK_DIV/2-1. First rise occurs CLK_DIV/2 cycles after entering RUN; first fall occurs CLK_DIV cycles after entering RUN.
- Fall event: the clk cycle in which bclk is registered 1->0. ws, sdata, pos, frame_start and underflow all update on that same clk edge. The DAC samples on the following bclk rise.
- Frame position: pos runs 0..2*WORD_SIZE-1, advancing once per fall and wrapping to 0.
  - Left slot: pos 0..WORD_SIZE-1.
  - Right slot: pos WORD_SIZE..2*WORD_SIZE-1.
- WS timing: ws leads data by one BCLK. The value driven at pos p is 1 for p in [WORD_SIZE-1, 2*WORD_SIZE-2], else 0.
- Data:
  - At pos p<WORD_SIZE, sdata = left_sh[DATA_BITS-1-p] if p<DATA_BITS, else 0.
  - Right slot is identical with p-WORD_SIZE and right_sh.
- Frame load at the pos 0 fall:
  - Holding buffer full: copy to left_sh/right_sh, mark buffer empty, pulse frame_start.
  - Holding buffer empty: load zeros, pulse both frame_start and underflow.
  - sample_ready rises the cycle after a load that emptied the buffer.
- Handshake:
  - Transfer occurs when sample_valid && sample_ready.
  - sample_ready = holding buffer empty.
  - Data is captured on the transfer edge; sample_ready drops the next cycle.
  - The holding buffer is never overwritten while full.
- Simultaneous transfer and load on an empty buffer: underflow fires, zeros are sent, and the new sample stays in the holding buffer for the next frame. There is no bypass path.
- While IDLE: handshakes are still accepted; no underflow is reported.

Optional Feature:
- Macro: I2S_TX_UNDERFLOW_REPEAT_EN.
- Defined: an underflowed frame reloads the previously transmitted left/right pair; the underflow pulse is still generated. The first frame after reset underflows with zeros.
- Undefined: an underflowed frame transmits zeros.

Test Plan:
- Bench config for all scenarios: CLK_DIV=4, WORD_SIZE=8, DATA_BITS=6.
- Basic frame: pre-load left=6'h2A, right=6'h15, enable=1. Required response:
  - first fall at clk 4
  - sdata left bits 1,0,1,0,1,0,0,0
  - sdata right bits 0,1,0,1,0,1,0,0
  - ws=1 from pos 7 through 14, 0 at pos 15
  - frame_start pulses once, underflow=0
- Backpressure: hold sample_valid=1 with changing data. Required response: exactly one transfer per frame; sample_ready=0 from the cycle after transfer until the cycle after the next pos 0 fall.
- Underflow: no sample supplied for frame 2. Required response: underflow pulses at frame 2 load; sdata is all zeros (with the macro: repeats 6'h2A/6'h15).
- Disable mid-frame: drop enable at pos 3. Required response: the frame finishes through pos 15, then bclk/ws/sdata go to 0 and no further falls occur.
- Async reset at pos 10: assert rst_n=0 between clk edges. Required response: all outputs take reset values immediately; after release with enable=1, the first fall comes CLK_DIV cycles later at pos 0.
- Same-cycle transfer and load with an empty buffer: underflow=1 and zeros sent; the following frame transmits the transferred sample.

Source files
------------

// File: rtl/i2s_tx_master.sv
// I2S (Philips) master transmitter: derives BCLK/WS from clk, serialises L/R PCM MSB-first.
// Build option: I2S_TX_UNDERFLOW_REPEAT_EN repeats the previous pair on underflow instead of zeros.
module i2s_tx_master #(
    parameter int CLK_DIV   = 64,
    parameter int WORD_SIZE = 32,
    parameter int DATA_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] left_data,
    input  logic [DATA_BITS-1:0] right_data,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic                 bclk,
    output logic                 ws,
    output logic                 sdata,
    output logic                 frame_start,
    output logic                 underflow
);
    localparam int HALF = CLK_DIV / 2;
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int PW   = $clog2(2 * WORD_SIZE);

    localparam logic [DW-1:0] DIV_LAST = DW'(HALF - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(2 * WORD_SIZE - 1);
    localparam logic [PW-1:0] WS_FIRST = PW'(WORD_SIZE - 1);
    localparam logic [PW-1:0] WS_LAST  = PW'(2 * WORD_SIZE - 2);
    localparam logic [PW-1:0] R_FIRST  = PW'(WORD_SIZE);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;

    logic [DW-1:0]        div_cnt;
    logic [PW-1:0]        pos;
    logic                 hold_full;
    logic [DATA_BITS-1:0] hold_l, hold_r;
    logic [DATA_BITS-1:0] left_sh, right_sh;
    logic [DATA_BITS-1:0] fill_l, fill_r, load_l, load_r;
    logic [DATA_BITS-1:0] slot_word, shifted;
    logic [PW-1:0]        slot_idx;
    logic                 tick, fall, frame_end, load, xfer;
    logic                 ws_d, sdata_d;

    assign tick      = (state_q == RUN) && (div_cnt == DIV_LAST);
    assign fall      = tick && bclk;
    assign frame_end = fall && (pos == '0) && !enable;
    assign load      = fall && (pos == '0) && enable;
    assign xfer      = sample_valid && !hold_full;
    assign sample_ready = !hold_full;

`ifdef I2S_TX_UNDERFLOW_REPEAT_EN
    assign fill_l = left_sh;
    assign fill_r = right_sh;
`else
    assign fill_l = '0;
    assign fill_r = '0;
`endif
    assign load_l = hold_full ? hold_l : fill_l;
    assign load_r = hold_full ? hold_r : fill_r;

    // Bit for the position about to be driven; pos 0 must see the word being loaded on this edge.
    // Shifting past DATA_BITS naturally yields the zero padding of the slot.
    always_comb begin
        slot_word = (pos >= R_FIRST) ? right_sh : ((pos == '0) ? load_l : left_sh);
        slot_idx  = (pos >= R_FIRST) ? (pos - R_FIRST) : pos;
        shifted   = slot_word << slot_idx;
        sdata_d   = shifted[DATA_BITS-1];
        ws_d      = (pos >= WS_FIRST) && (pos <= WS_LAST);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (frame_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Holding buffer: a transfer only happens when empty, so it never overwrites a pending pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
        end else if (xfer) begin
            hold_full <= 1'b1;
            hold_l    <= left_data;
            hold_r    <= right_data;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            pos         <= '0;
            bclk        <= 1'b0;
            ws          <= 1'b0;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            left_sh     <= '0;
            right_sh    <= '0;
        end else begin
            frame_start <= load;
            underflow   <= load && !hold_full;
            if (state_q == IDLE || frame_end) begin
                div_cnt <= '0;
                pos     <= '0;
                bclk    <= 1'b0;
                ws      <= 1'b0;
                sdata   <= 1'b0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) bclk <= !bclk;
                if (fall) begin
                    ws    <= ws_d;
                    sdata <= sdata_d;
                    pos   <= (pos == POS_LAST) ? '0 : pos + 1'b1;
                end
                if (load) begin
                    left_sh  <= load_l;
                    right_sh <= load_r;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx_master.sv
// Directed + randomized bench for i2s_tx_master against a cycle-count based frame model.
module tb_i2s_tx_master;
    localparam int CLK_DIV   = 4;
    localparam int WORD_SIZE = 8;
    localparam int DATA_BITS = 6;
    localparam int HALF      = CLK_DIV / 2;
    localparam int FRAME     = 2 * WORD_SIZE;
    localparam int PAD       = WORD_SIZE - DATA_BITS;

    logic clk = 1'b0, rst_n = 1'b1, enable = 1'b0, sample_valid = 1'b0;
    logic [DATA_BITS-1:0] left_data = '0, right_data = '0;
    logic sample_ready, bclk, ws, sdata, frame_start, underflow;

    i2s_tx_master #(.CLK_DIV(CLK_DIV), .WORD_SIZE(WORD_SIZE), .DATA_BITS(DATA_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .left_data(left_data),
        .right_data(right_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .bclk(bclk), .ws(ws), .sdata(sdata), .frame_start(frame_start), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model state
    bit m_run, m_full, m_fall, m_load, m_xfer;
    int k, m_pos, xfer_cnt;
    logic [DATA_BITS-1:0] m_hl, m_hr, f_l, f_r;
    logic exp_bclk, exp_ws, exp_sd, exp_fs, exp_uf;
    bit refill, cap_on;
    logic [FRAME-1:0] cap_sd, cap_ws;
    int fs_cnt, uf_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input int p);
        logic [FRAME-1:0] w;
        w = {f_l, {PAD{1'b0}}, f_r, {PAD{1'b0}}};
        return w[FRAME-1-p];
    endfunction

    task automatic model_reset();
        m_run = 0; m_full = 0; m_fall = 0; m_load = 0; k = 0; m_pos = 0;
        m_hl = '0; m_hr = '0; f_l = '0; f_r = '0;
        exp_bclk = 0; exp_ws = 0; exp_sd = 0; exp_fs = 0; exp_uf = 0;
    endtask

    task automatic check_outs();
        chk("bclk", 32'(bclk), 32'(exp_bclk));
        chk("ws", 32'(ws), 32'(exp_ws));
        chk("sdata", 32'(sdata), 32'(exp_sd));
        chk("sample_ready", 32'(sample_ready), 32'(!m_full));
        chk("frame_start", 32'(frame_start), 32'(exp_fs));
        chk("underflow", 32'(underflow), 32'(exp_uf));
    endtask

    // One clock: advance the model from pre-edge inputs, then compare every output.
    task automatic cyc();
        logic pre_en, pre_v, pre_rdy;
        logic [DATA_BITS-1:0] pl, pr;
        int p;
        pre_en = enable; pre_v = sample_valid; pre_rdy = !m_full;
        pl = left_data; pr = right_data;
        @(posedge clk); #1;
        m_fall = 0; m_load = 0; m_xfer = 0; exp_fs = 0; exp_uf = 0;
        if (!m_run) begin
            if (pre_en) begin m_run = 1; k = 0; end
        end else begin
            k++;
            exp_bclk = ((k / HALF) % 2) == 1;
            if (k % CLK_DIV == 0) begin
                p = (k / CLK_DIV - 1) % FRAME;
                if (p == 0 && !pre_en) begin
                    m_run = 0; exp_bclk = 0; exp_ws = 0; exp_sd = 0;
                end else begin
                    if (p == 0) begin
                        m_load = 1; exp_fs = 1;
                        if (m_full) begin
                            f_l = m_hl; f_r = m_hr; m_full = 0;
                        end else begin
                            exp_uf = 1;
`ifndef I2S_TX_UNDERFLOW_REPEAT_EN
                            f_l = '0; f_r = '0;
`endif
                        end
                    end
                    m_fall = 1; m_pos = p;
                    exp_ws = (p >= WORD_SIZE - 1) && (p <= FRAME - 2);
                    exp_sd = frame_bit(p);
                end
            end
        end
        if (pre_v && pre_rdy) begin
            m_full = 1; m_hl = pl; m_hr = pr; m_xfer = 1; xfer_cnt++;
        end
        check_outs();
        if (cap_on) begin
            if (m_fall) begin
                cap_sd[FRAME-1-m_pos] = sdata;
                cap_ws[FRAME-1-m_pos] = ws;
            end
            fs_cnt += int'(frame_start);
            uf_cnt += int'(underflow);
        end
        if (refill) begin
            left_data = DATA_BITS'($urandom);
            right_data = DATA_BITS'($urandom);
        end else if (m_xfer) begin
            sample_valid = 1'b0;
        end
    endtask

    task automatic run_to_pos(input int target);
        int n;
        bit reached;
        n = 0; reached = 0;
        while (!reached && n < 400) begin
            cyc(); n++;
            reached = m_fall && (m_pos == target);
        end
        chk("reach_pos", 32'(reached), 32'd1);
    endtask

    task automatic run_to_load();
        int n;
        n = 0;
        do begin cyc(); n++; end while (!m_load && n < 400);
        chk("reach_load", 32'(m_load), 32'd1);
    endtask

    task automatic first_fall(input string tag);
        int n;
        logic pb;
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            pb = bclk;
            cyc();
            if (pb && !bclk) n = i;
        end
        chk(tag, 32'(n), 32'(1 + CLK_DIV));
    endtask

    initial begin
        logic [DATA_BITS-1:0] sl, sr;
        int n, rises;
        logic pb;
        model_reset();
        refill = 0; cap_on = 0; xfer_cnt = 0; fs_cnt = 0; uf_cnt = 0;
        cap_sd = '0; cap_ws = '0;

        #1 rst_n = 1'b0;
        #2 check_outs();
        #1 rst_n = 1'b1;
        repeat (3) cyc();

        // Basic frame
        left_data = 6'h2A; right_data = 6'h15; sample_valid = 1'b1;
        cyc(); cyc();
        enable = 1'b1;
        cap_on = 1; fs_cnt = 0; uf_cnt = 0;
        first_fall("first_fall_cycle");
        run_to_pos(FRAME - 1);
        cap_on = 0;
        chk("frame1_sdata", 32'(cap_sd), 32'h0000A854);
        chk("frame1_ws", 32'(cap_ws), 32'h000001FE);
        chk("frame1_fs_count", 32'(fs_cnt), 32'd1);
        chk("frame1_uf_count", 32'(uf_cnt), 32'd0);

        // Underflow on frame 2
        cap_on = 1; fs_cnt = 0; uf_cnt = 0;
        run_to_pos(FRAME - 1);
        cap_on = 0;
        chk("frame2_uf_count", 32'(uf_cnt), 32'd1);
`ifdef I2S_TX_UNDERFLOW_REPEAT_EN
        chk("frame2_sdata", 32'(cap_sd), 32'h0000A854);
`else
        chk("frame2_sdata", 32'(cap_sd), 32'h00000000);
`endif

        // Backpressure with valid held and data changing every cycle
        refill = 1; sample_valid = 1'b1;
        left_data = DATA_BITS'($urandom); right_data = DATA_BITS'($urandom);
        run_to_load();
        xfer_cnt = 0;
        repeat (3) run_to_load();
        chk("xfers_per_3_frames", 32'(xfer_cnt), 32'd3);
        refill = 0; sample_valid = 1'b0;

        // Disable mid-frame
        run_to_pos(3);
        enable = 1'b0;
        run_to_pos(FRAME - 1);
        repeat (8) cyc();
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            pb = bclk;
            cyc();
            if (!pb && bclk) rises++;
        end
        chk("idle_bclk_rises", 32'(rises), 32'd0);

        // Async reset mid-frame
        enable = 1'b1;
        run_to_pos(10);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outs();
        #1 rst_n = 1'b1;
        first_fall("post_reset_fall");

        // Transfer and load on the same edge with an empty buffer
        n = 0;
        while (!(m_run && ((k + 1) % CLK_DIV == 0) && (((k + 1) / CLK_DIV - 1) % FRAME == 0)
                 && (k + 1 >= CLK_DIV)) && n < 200) begin
            cyc(); n++;
        end
        sl = DATA_BITS'($urandom); sr = DATA_BITS'($urandom);
        left_data = sl; right_data = sr; sample_valid = 1'b1;
        cap_on = 1;
        cyc();
        chk("same_cycle_uf", 32'(underflow), 32'd1);
        chk("same_cycle_ready", 32'(sample_ready), 32'd0);
        run_to_pos(FRAME - 1);
        chk("same_cycle_zero_frame", 32'(cap_sd), 32'h00000000);
        run_to_pos(FRAME - 1);
        cap_on = 0;
        chk("same_cycle_next_frame", 32'(cap_sd), 32'({sl, {PAD{1'b0}}, sr, {PAD{1'b0}}}));

        enable = 1'b0;
        repeat (80) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
